// File: rtl/edge_gen_pkg.sv
// Shared types and sizing helpers for the edge_gen falling-edge pulse generator.
package edge_gen_pkg;

    typedef enum logic [1:0] {
        EG_IDLE = 2'd0,
        EG_LOW  = 2'd1,
        EG_GAP  = 2'd2
    } eg_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int eg_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/edge_gen_pulse_timer.sv
// Loadable down-counter that times both the LOW and GAP phases; done is high at zero.
module pulse_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/edge_gen.sv
// Trigger-to-active-low pulse generator with guaranteed low time and recovery gap.
// Define EDGE_GEN_QUEUE_EN to queue triggers that arrive while busy (up to PEND_DEPTH).
module edge_gen
    import edge_gen_pkg::*;
#(
    parameter int LOW_CYCLES = 4,
    parameter int GAP_CYCLES = 2,
    parameter int PEND_DEPTH = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                trig,
    output logic                                q,
    output logic                                busy,
    output logic [eg_width(PEND_DEPTH+1)-1:0]   pending,
    output logic                                drop
);

    localparam int CW = eg_width((LOW_CYCLES > GAP_CYCLES) ? LOW_CYCLES : GAP_CYCLES);
    localparam int PW = eg_width(PEND_DEPTH + 1);
    localparam logic [CW-1:0] LOW_LOAD = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    eg_state_e      state_q;
    eg_state_e      state_d;
    logic           tmr_load;
    logic [CW-1:0]  tmr_val;
    logic           tmr_done;
    logic           gap_end;
    logic           trig_direct;
    logic           trig_busy;
    logic [PW-1:0]  pend_d;
    logic           drop_d;

    pulse_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    assign gap_end = (state_q == EG_GAP) && tmr_done;

    // Queued triggers launch ahead of a fresh one, so a trig in the last GAP
    // cycle only launches directly when nothing is pending.
    assign trig_direct = trig && ((state_q == EG_IDLE) || (gap_end && (pending == '0)));
    assign trig_busy   = trig && !trig_direct;

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = LOW_LOAD;
        case (state_q)
            EG_IDLE: begin
                if (trig) begin
                    state_d  = EG_LOW;
                    tmr_load = 1'b1;
                end
            end
            EG_LOW: begin
                if (tmr_done) begin
                    state_d  = EG_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            EG_GAP: begin
                if (tmr_done) begin
                    if ((pending != '0) || trig) begin
                        state_d  = EG_LOW;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = EG_IDLE;
                    end
                end
            end
            default: state_d = EG_IDLE;
        endcase
    end

`ifdef EDGE_GEN_QUEUE_EN
    localparam logic [PW-1:0] PEND_MAX = PW'(PEND_DEPTH);
    logic pend_pop;

    assign pend_pop = gap_end && (pending != '0);

    always_comb begin
        pend_d = pending;
        drop_d = 1'b0;
        if (trig_busy && !pend_pop) begin
            if (pending < PEND_MAX) begin
                pend_d = pending + 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end else if (pend_pop && !trig_busy) begin
            pend_d = pending - 1'b1;
        end
    end
`else
    always_comb begin
        pend_d = '0;
        drop_d = trig_busy;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EG_IDLE;
            q       <= 1'b1;
            busy    <= 1'b0;
            pending <= '0;
            drop    <= 1'b0;
        end else begin
            state_q <= state_d;
            q       <= (state_d != EG_LOW);
            busy    <= (state_d != EG_IDLE);
            pending <= pend_d;
            drop    <= drop_d;
        end
    end

endmodule

// File: tb/tb_edge_gen.sv
// Self-checking bench for edge_gen: pulse-schedule model plus directed literal checks.
module tb_edge_gen;

    localparam int L = 4;
    localparam int G = 2;
    localparam int D = 3;
`ifdef EDGE_GEN_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trig = 1'b0;
    logic       q;
    logic       busy;
    logic [1:0] pending;
    logic       drop;

    always #5 clk = ~clk;

    edge_gen #(.LOW_CYCLES(L), .GAP_CYCLES(G), .PEND_DEPTH(D)) dut (
        .clk     (clk),
        .reset   (reset),
        .trig    (trig),
        .q       (q),
        .busy    (busy),
        .pending (pending),
        .drop    (drop)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pulse launched at edge s is low after edges s..s+L-1 and busy
    // until edge s+L+G, where the next launch (queued first, then trig) may start.
    int  e      = 0;
    int  m_s    = 0;
    int  m_pend = 0;
    bit  m_act  = 1'b0;
    bit  m_drop = 1'b0;
    bit  m_seed = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            e++;
            m_drop = 1'b0;
            if (reset) begin
                m_act  = 1'b0;
                m_pend = 0;
                m_seed = 1'b1;
            end else if (m_act && (e == m_s + L + G)) begin
                if (m_pend > 0) begin
                    m_s = e;
                    m_pend--;
                    if (trig) m_pend++;
                end else if (trig) begin
                    m_s = e;
                end else begin
                    m_act = 1'b0;
                end
            end else if (!m_act) begin
                if (trig) begin
                    m_act = 1'b1;
                    m_s   = e;
                end
            end else if (trig) begin
                if (QEN && (m_pend < D)) m_pend++;
                else m_drop = 1'b1;
            end
            @(negedge clk);
            if (m_seed) begin
                check("model_q",       q,       (m_act && (e - m_s < L)) ? 0 : 1);
                check("model_busy",    busy,    m_act ? 1 : 0);
                check("model_pending", pending, m_pend);
                check("model_drop",    drop,    m_drop ? 1 : 0);
            end
        end
    end

    task automatic step(input logic t, input logic r = 1'b0);
        trig  = t;
        reset = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and idle
        repeat (3) step(1'b0, 1'b1);
        check("rst_q", q, 1);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_drop", drop, 0);
        repeat (10) step(1'b0);
        check("idle_q", q, 1);
        check("idle_busy", busy, 0);

        // Single trigger
        step(1'b1);
        check("s1_q_e0", q, 0);
        check("s1_busy_e0", busy, 1);
        repeat (3) step(1'b0);
        check("s1_q_e3", q, 0);
        step(1'b0);
        check("s1_q_e4", q, 1);
        check("s1_busy_e4", busy, 1);
        step(1'b0);
        check("s1_busy_e5", busy, 1);
        step(1'b0);
        check("s1_busy_e6", busy, 0);
        repeat (4) step(1'b0);

        // Triggers at edges 0, 2, 3
        step(1'b1);
        step(1'b0);
        step(1'b1);
        check("s2_pending_e2", pending, QEN ? 1 : 0);
        check("s2_drop_e2", drop, QEN ? 0 : 1);
        step(1'b1);
        check("s2_pending_e3", pending, QEN ? 2 : 0);
        repeat (3) step(1'b0);
        check("s2_q_e6", q, QEN ? 0 : 1);
        repeat (6) step(1'b0);
        check("s2_q_e12", q, QEN ? 0 : 1);
        check("s2_pending_e12", pending, 0);
        repeat (12) step(1'b0);

        // Trigger every cycle for 8 cycles
        repeat (4) step(1'b1);
        check("s3_pending_e3", pending, QEN ? 3 : 0);
        step(1'b1);
        check("s3_drop_e4", drop, 1);
        step(1'b1);
        step(1'b1);
        check("s3_q_e6", q, 0);
        check("s3_drop_e6", drop, 0);
        check("s3_pending_e6", pending, QEN ? 3 : 0);
        step(1'b1);
        check("s3_drop_e7", drop, 1);
        repeat (30) step(1'b0);

        // Trigger exactly at the last GAP edge, then one mid-pulse
        step(1'b1);
        repeat (5) step(1'b0);
        step(1'b1);
        check("s4_q_e6", q, 0);
        check("s4_pending_e6", pending, 0);
        check("s4_drop_e6", drop, 0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        check("s4_drop_mid", drop, QEN ? 0 : 1);
        check("s4_pending_mid", pending, QEN ? 1 : 0);
        repeat (20) step(1'b0);

        // Reset mid-pulse with triggers queued, trig coincident with reset
        repeat (3) step(1'b1);
        check("s5_pending_e2", pending, QEN ? 2 : 0);
        step(1'b1, 1'b1);
        check("s5_q_rst", q, 1);
        check("s5_busy_rst", busy, 0);
        check("s5_pending_rst", pending, 0);
        repeat (15) step(1'b0);
        check("s5_q_after", q, 1);
        check("s5_busy_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
